// File: rtl/dnn_pkg.sv
// Shared types and constants for the activation-memory datapath blocks.
package dnn_pkg;

    localparam int IDX_W             = 16;
    localparam int DEFAULT_DATA_SIZE = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/act_mem_streamer_if.sv
// Valid/ready word stream with a last flag, as produced by act_mem_streamer.
interface act_stream_if #(
    parameter int DATA_SIZE = dnn_pkg::DEFAULT_DATA_SIZE
);

    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/act_mem_streamer_raster_counter.sv
// Nested x/y/entry raster counter: x fastest, entry pointer wraps modulo ENTRY_NUM.
module raster_counter
    import dnn_pkg::*;
#(
    parameter int ENTRY_NUM = 16,
    parameter int SPAN      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [IDX_W-1:0] i_base,
    input  logic             i_adv,
    output logic [IDX_W-1:0] o_entry,
    output logic [IDX_W-1:0] o_y,
    output logic [IDX_W-1:0] o_x,
    output logic             o_tile_last
);

    localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_POS  = IDX_W'(SPAN - 1);
    localparam logic [IDX_W-1:0] ENTRY_LIM = IDX_W'(ENTRY_NUM);

    logic [IDX_W-1:0] r_entry;
    logic [IDX_W-1:0] r_y;
    logic [IDX_W-1:0] r_x;
    logic [IDX_W-1:0] w_entryInc;
    logic [IDX_W-1:0] w_entryNext;

    assign w_entryInc  = r_entry + ONE;
    assign w_entryNext = (w_entryInc == ENTRY_LIM) ? '0 : w_entryInc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
            r_y     <= '0;
            r_x     <= '0;
        end else if (i_load) begin
            r_entry <= i_base;
            r_y     <= '0;
            r_x     <= '0;
        end else if (i_adv) begin
            if (r_x == LAST_POS) begin
                r_x <= '0;
                if (r_y == LAST_POS) begin
                    r_y     <= '0;
                    r_entry <= w_entryNext;
                end else begin
                    r_y <= r_y + ONE;
                end
            end else begin
                r_x <= r_x + ONE;
            end
        end
    end

    assign o_entry     = r_entry;
    assign o_y         = r_y;
    assign o_x         = r_x;
    assign o_tile_last = (r_x == LAST_POS) && (r_y == LAST_POS);

endmodule

// File: rtl/act_mem_streamer.sv
// Sequential activation-memory reader streaming num_entries tiles in raster order.
// Optional zero-pad ring per tile enabled by defining ACT_STREAM_PAD_EN.
module act_mem_streamer
    import dnn_pkg::*;
#(
    parameter int ENTRY_NUM = 16,
    parameter int DIM       = 1,
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int PAD       = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [IDX_W-1:0]     base_entry,
    input  logic [IDX_W-1:0]     num_entries,
    input  logic                 abort,
    output logic [IDX_W-1:0]     read_index_entry,
    output logic [IDX_W-1:0]     read_index_y,
    output logic [IDX_W-1:0]     read_index_x,
    input  logic [DATA_SIZE-1:0] mem_data,
    act_stream_if.master         out_s,
    output logic                 busy,
    output logic                 done
);

`ifdef ACT_STREAM_PAD_EN
    localparam int PAD_ON = 1;
`else
    localparam int PAD_ON = 0;
`endif
    localparam int SPAN = DIM + 2 * PAD * PAD_ON;
    localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

    state_e               r_state;
    logic [IDX_W-1:0]     r_remaining;
    logic [DATA_SIZE-1:0] r_outData;
    logic                 r_outValid;
    logic                 r_outLast;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_load;
    logic                 w_adv;
    logic                 w_tileLast;
    logic                 w_final;
    logic [IDX_W-1:0]     w_entry;
    logic [IDX_W-1:0]     w_y;
    logic [IDX_W-1:0]     w_x;
    logic [DATA_SIZE-1:0] w_wordIn;

    // abort outranks both a new start and the advance condition
    assign w_load  = (r_state == ST_IDLE) && start && !abort;
    assign w_adv   = (r_state == ST_RUN) && !abort && (!r_outValid || out_s.out_ready);
    assign w_final = w_tileLast && (r_remaining == ONE);

    raster_counter #(
        .ENTRY_NUM (ENTRY_NUM),
        .SPAN      (SPAN)
    ) u_raster (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_base      (base_entry),
        .i_adv       (w_adv),
        .o_entry     (w_entry),
        .o_y         (w_y),
        .o_x         (w_x),
        .o_tile_last (w_tileLast)
    );

`ifdef ACT_STREAM_PAD_EN
    localparam logic [IDX_W-1:0] PAD_L = IDX_W'(PAD);
    localparam logic [IDX_W-1:0] HI_L  = IDX_W'(DIM + PAD);

    logic w_padY;
    logic w_padX;

    // Ring positions read index 0 and substitute a zero word
    assign w_padY           = (w_y < PAD_L) || (w_y >= HI_L);
    assign w_padX           = (w_x < PAD_L) || (w_x >= HI_L);
    assign read_index_entry = w_entry;
    assign read_index_y     = w_padY ? '0 : (w_y - PAD_L);
    assign read_index_x     = w_padX ? '0 : (w_x - PAD_L);
    assign w_wordIn         = (w_padY || w_padX) ? '0 : mem_data;
`else
    assign read_index_entry = w_entry;
    assign read_index_y     = w_y;
    assign read_index_x     = w_x;
    assign w_wordIn         = mem_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_outData   <= '0;
            r_outValid  <= 1'b0;
            r_outLast   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_remaining <= num_entries;
                        if (num_entries == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_adv) begin
                        r_outData  <= w_wordIn;
                        r_outValid <= 1'b1;
                        if (w_tileLast) begin
                            r_remaining <= r_remaining - ONE;
                        end
                        if (w_final) begin
                            r_outLast <= 1'b1;
                            r_state   <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state    <= ST_IDLE;
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (r_outValid && out_s.out_ready) begin
                        r_state    <= ST_IDLE;
                        r_outValid <= 1'b0;
                        r_outLast  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_outValid <= 1'b0;
                    r_outLast  <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign out_s.out_data  = r_outData;
    assign out_s.out_valid = r_outValid;
    assign out_s.out_last  = r_outLast;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

// File: tb/tb_act_mem_streamer.sv
// Directed scoreboard bench for act_mem_streamer (DIM=2, ENTRY_NUM=4, mem[e][y][x]=e*4+y*2+x).
module tb_act_mem_streamer;
    import dnn_pkg::*;

    localparam int ENTRY_NUM = 4;
    localparam int DIM       = 2;
    localparam int DATA_SIZE = 64;
    localparam int PAD       = 1;
`ifdef ACT_STREAM_PAD_EN
    localparam int T = DIM + 2 * PAD;
`else
    localparam int T = DIM;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic [15:0]          base_entry = '0;
    logic [15:0]          num_entries = '0;
    logic [15:0]          read_index_entry;
    logic [15:0]          read_index_y;
    logic [15:0]          read_index_x;
    logic [DATA_SIZE-1:0] mem_data;
    logic                 busy;
    logic                 done;

    int errors = 0;
    int checks = 0;
    logic [64:0] expQ[$];

    act_stream_if #(.DATA_SIZE(DATA_SIZE)) outS ();

    act_mem_streamer #(
        .ENTRY_NUM (ENTRY_NUM),
        .DIM       (DIM),
        .DATA_SIZE (DATA_SIZE),
        .PAD       (PAD)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .base_entry       (base_entry),
        .num_entries      (num_entries),
        .abort            (abort),
        .read_index_entry (read_index_entry),
        .read_index_y     (read_index_y),
        .read_index_x     (read_index_x),
        .mem_data         (mem_data),
        .out_s            (outS.master),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        mem_data = 64'(read_index_entry) * 64'(DIM * DIM) + 64'(read_index_y) * 64'(DIM) + 64'(read_index_x);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] expWord(input int e, input int y, input int x);
`ifdef ACT_STREAM_PAD_EN
        if (y < PAD || y >= DIM + PAD || x < PAD || x >= DIM + PAD) return 64'd0;
        return 64'(e * DIM * DIM + (y - PAD) * DIM + (x - PAD));
`else
        return 64'(e * DIM * DIM + y * DIM + x);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one request; readyMode 0 = ready held high, 1 = ready toggling; abortAfter>0 aborts after that many transfers
    task automatic applyStimulus(input logic [15:0] base, input logic [15:0] cnt,
                                 input int readyMode, input int abortAfter, input string tag);
        int cyc, xfers, firstValid, lastXferCyc, abortState, words, e;
        bit doneDue, finished, stalled;
        logic [DATA_SIZE-1:0] held;
        logic [64:0] expItem;

        expQ.delete();
        words = 0;
        for (int k = 0; k < int'(cnt); k++) begin
            e = (int'(base) + k) % ENTRY_NUM;
            for (int y = 0; y < T; y++) begin
                for (int x = 0; x < T; x++) begin
                    expQ.push_back({(k == int'(cnt) - 1 && y == T - 1 && x == T - 1), expWord(e, y, x)});
                    words++;
                end
            end
        end

        @(negedge clk);
        start = 1'b1;
        base_entry = base;
        num_entries = cnt;
        outS.out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; xfers = 0; firstValid = -1; lastXferCyc = -1; abortState = 0;
        doneDue = (cnt == 0); finished = 0; stalled = 0; held = '0;

        while (!finished && cyc < 400) begin
            outS.out_ready = (readyMode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (abortState == 1) begin
                abort = 1'b1;
                abortState = 2;
            end else if (abortState == 2) begin
                abort = 1'b0;
                checkOutput({tag, "_abort_valid"}, 64'(outS.out_valid), 64'd0);
                checkOutput({tag, "_abort_busy"}, 64'(busy), 64'd0);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput({tag, "_abort_no_done"}, 64'(done), 64'd0);
                end
                finished = 1;
            end else begin
                checkOutput({tag, "_done"}, 64'(done), 64'(doneDue));
                if (doneDue) begin
                    checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
                    checkOutput({tag, "_valid_after"}, 64'(outS.out_valid), 64'd0);
                    checkOutput({tag, "_words_left"}, 64'(expQ.size()), 64'd0);
                    finished = 1;
                end else begin
                    if (stalled) checkOutput({tag, "_stall_hold"}, outS.out_data, held);
                    if (outS.out_valid && firstValid < 0) firstValid = cyc;
                    if (outS.out_valid && outS.out_ready) begin
                        if (expQ.size() == 0) begin
                            checkOutput({tag, "_extra_word"}, outS.out_data, 64'hDEAD);
                        end else begin
                            expItem = expQ.pop_front();
                            checkOutput({tag, "_data"}, outS.out_data, expItem[63:0]);
                            checkOutput({tag, "_last"}, 64'(outS.out_last), 64'(expItem[64]));
                            doneDue = expItem[64];
                        end
                        xfers++;
                        lastXferCyc = cyc;
                        if (abortAfter > 0 && xfers == abortAfter) abortState = 1;
                    end
                    stalled = outS.out_valid && !outS.out_ready;
                    held = outS.out_data;
                end
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!finished) checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
        if (readyMode == 0 && abortAfter == 0 && cnt != 0) begin
            checkOutput({tag, "_first_valid_latency"}, 64'(firstValid), 64'd2);
            checkOutput({tag, "_last_xfer_cycle"}, 64'(lastXferCyc), 64'(words + 1));
        end
        abort = 1'b0;
        expQ.delete();
    endtask

    initial begin
        outS.out_ready = 1'b1;
        #12;
        checkOutput("reset_data", outS.out_data, 64'd0);
        checkOutput("reset_valid", 64'(outS.out_valid), 64'd0);
        checkOutput("reset_last", 64'(outS.out_last), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_idx", {16'd0, read_index_entry, read_index_y, read_index_x}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(16'd1, 16'd2, 0, 0, "run_ready");
        applyStimulus(16'd1, 16'd2, 1, 0, "run_stall");
        applyStimulus(16'd3, 16'd2, 0, 0, "run_wrap");
        applyStimulus(16'd0, 16'd0, 0, 0, "run_zero");
        applyStimulus(16'd1, 16'd2, 0, 3, "run_abort");
        applyStimulus(16'd0, 16'd1, 0, 0, "run_restart");
        applyStimulus(16'd2, 16'd1, 1, 0, "run_stall_one");

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1; base_entry = 16'd0; num_entries = 16'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrun_valid_before", 64'(outS.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun_rst_valid", 64'(outS.out_valid), 64'd0);
        checkOutput("midrun_rst_data", outS.out_data, 64'd0);
        checkOutput("midrun_rst_last", 64'(outS.out_last), 64'd0);
        checkOutput("midrun_rst_busy", 64'(busy), 64'd0);
        checkOutput("midrun_rst_idx", {16'd0, read_index_entry, read_index_y, read_index_x}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrun_no_done", 64'(done), 64'd0);
        checkOutput("midrun_idle_valid", 64'(outS.out_valid), 64'd0);

        applyStimulus(16'd1, 16'd1, 0, 0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
